// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//
// Two-master arbiter for the shared slave data bus. Master 0 is the CPU bus
// interface and master 1 is a secondary master such as DMA or debug. Ownership
// alternates round-robin. An optional hold timeout stops one master from
// keeping the bus indefinitely while the other master is waiting.
//
// Parameters
//   MAX_HOLD     Cycles an owner may hold the bus while the other master is
//                requesting. 0 disables preemption. Legal range is 0..255.
//
// Ports
//   clk          clock
//   rst          asynchronous reset, active low
//   m0_*         master 0: bus_req in, bus_grant out, addr/wr/rd/data in
//   m1_*         master 1: same set of signals as master 0
//   s_addr/s_wr/s_rd/s_data
//                slave bus, driven by the current owner; all zero when idle
//   bus_owner    one-hot owner {m1,m0}; 00 means the bus is idle
//
// Slave read data goes straight back to the masters and does not pass
// through this block.
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_bus_req,
    output logic       m0_bus_grant,
    input  logic [7:0] m0_addr,
    input  logic       m0_wr,
    input  logic       m0_rd,
    input  logic [7:0] m0_data,
    input  logic       m1_bus_req,
    output logic       m1_bus_grant,
    input  logic [7:0] m1_addr,
    input  logic       m1_wr,
    input  logic       m1_rd,
    input  logic [7:0] m1_data,
    output logic [7:0] s_addr,
    output logic       s_wr,
    output logic       s_rd,
    output logic [7:0] s_data,
    output logic [1:0] bus_owner
);

    // One-hot state encoding. Each grant is a state flop bit, so the grants
    // come straight from registers and can never glitch high together.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam bit         PREEMPT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = PREEMPT_EN ? 8'(MAX_HOLD - 1) : 8'd0;

    state_t     state_reg, state_next;
    logic       last_owner_reg, last_owner_next;   // 0 = m0, 1 = m1
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic       preempt;

    // Preemption fires only on the exact last allowed cycle. If the owner ran
    // past that point alone, the saturated counter never matches again.
    // In that case the owner keeps the bus until it releases it.
    assign preempt = PREEMPT_EN && m0_bus_req && m1_bus_req
                     && (hold_cnt_reg == HOLD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;     // makes master 0 win the first contention
            hold_cnt_reg   <= 8'd0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (m0_bus_req && m1_bus_req)
                    state_next = last_owner_reg ? OWN0 : OWN1;
                else if (m0_bus_req)
                    state_next = OWN0;
                else if (m1_bus_req)
                    state_next = OWN1;
            end
            OWN0: begin
                if (!m0_bus_req && m1_bus_req)
                    state_next = OWN1;          // direct handoff, no idle gap
                else if (!m0_bus_req)
                    state_next = IDLE;
                else if (preempt)
                    state_next = OWN1;
            end
            OWN1: begin
                if (!m1_bus_req && m0_bus_req)
                    state_next = OWN0;
                else if (!m1_bus_req)
                    state_next = IDLE;
                else if (preempt)
                    state_next = OWN0;
            end
            default: state_next = IDLE;
        endcase

        // Update tenure bookkeeping from the chosen transition.
        if (state_next == IDLE) begin
            hold_cnt_next = 8'd0;
        end else if (state_next != state_reg) begin
            hold_cnt_next   = 8'd0;
            last_owner_next = (state_next == OWN1);
        end else if (hold_cnt_reg != 8'hFF) begin
            hold_cnt_next = hold_cnt_reg + 8'd1;
        end
    end

    assign m0_bus_grant = state_reg[0];
    assign m1_bus_grant = state_reg[1];
    assign bus_owner    = {m1_bus_grant, m0_bus_grant};

    // Slave bus mux. The select comes from registered state, so an ungranted
    // master cannot reach the slaves, whatever it drives.
    always_comb begin
        s_addr = 8'd0;
        s_wr   = 1'b0;
        s_rd   = 1'b0;
        s_data = 8'd0;
        case (state_reg)
            OWN0: begin
                s_addr = m0_addr;
                s_wr   = m0_wr;
                s_rd   = m0_rd;
                s_data = m0_data;
            end
            OWN1: begin
                s_addr = m1_addr;
                s_wr   = m1_wr;
                s_rd   = m1_rd;
                s_data = m1_data;
            end
            default: ;
        endcase
    end

endmodule
